// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-path definitions: fetch FSM encoding, instruction width, bubble value
// and the buffered {PC+4, instruction} entry used by IF/ID and the hazard unit.
package if_fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc4;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Two-entry fetch buffer of {PC+4, instruction} with push/pop/flush and occupancy.
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
(
  input  logic         Clock_i,
  input  logic         Reset_n_i,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_q;
  logic         wr_q;

  always_ff @(posedge Clock_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      count <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_q] <= push_entry;
        wr_q      <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_q];

  // The single outstanding request and the issue rule keep a free slot for every push.
  assert property (@(posedge Clock_i) disable iff (!Reset_n_i)
    !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding memory read
// at a time and feeds IF/ID from a two-entry buffer, with stall and redirect handling.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clock_i,
  input  logic              Reset_n_i,
  input  logic              Stall_i,
  input  logic              Redirect_i,
  input  logic [31:0]       RedirectPC_i,
  output logic              IMemReq_o,
  output logic [31:0]       IMemAddr_o,
  input  logic              IMemAck_i,
  input  logic [INST_W-1:0] IMemData_i,
  output logic              Valid_o,
  output logic [31:0]       PC4_o,
  output logic [INST_W-1:0] Inst_o
);

  fetch_state_e state_q, state_d;
  logic         req_d;
  logic [31:0]  addr_d;
  logic [31:0]  npc_q, npc_d;

  logic         xfer;
  logic         push;
  logic         pop;
  logic [1:0]   occ;
  logic [1:0]   occ_next;
  logic         issue_ok;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic [1:0]   unused_redirect_lsb;

  assign unused_redirect_lsb = RedirectPC_i[1:0];

  assign xfer = IMemReq_o & IMemAck_i;
  assign push = xfer && (state_q == FETCH_REQ) && !Redirect_i;
  assign pop  = (occ != 2'd0) && !Stall_i && !Redirect_i;

  assign occ_next = Redirect_i ? 2'd0 : (occ + 2'(push) - 2'(pop));
  assign issue_ok = ((state_q == FETCH_IDLE) || xfer) && (occ_next <= 2'd1);

  assign push_entry.pc4  = IMemAddr_o + 32'd4;
  assign push_entry.inst = IMemData_i;

  if_fetch_fifo u_fifo (
    .Clock_i    (Clock_i),
    .Reset_n_i  (Reset_n_i),
    .flush      (Redirect_i),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (occ)
  );

  always_ff @(posedge Clock_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q    <= FETCH_IDLE;
      IMemReq_o  <= 1'b0;
      IMemAddr_o <= '0;
      npc_q      <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q    <= state_d;
      IMemReq_o  <= req_d;
      IMemAddr_o <= addr_d;
      npc_q      <= npc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = IMemReq_o;
    addr_d  = IMemAddr_o;
    npc_d   = npc_q;
    if (Redirect_i) begin
      npc_d = {RedirectPC_i[31:2], 2'b00};
      // An unfinished request cannot be withdrawn, so its data is marked for discard.
      if (IMemReq_o && !xfer) begin
        state_d = FETCH_KILL;
      end else begin
        state_d = FETCH_IDLE;
        req_d   = 1'b0;
      end
    end else if (issue_ok) begin
      state_d = FETCH_REQ;
      req_d   = 1'b1;
      addr_d  = npc_q;
      npc_d   = npc_q + 32'd4;
    end else if (xfer) begin
      state_d = FETCH_IDLE;
      req_d   = 1'b0;
    end
  end

  assign Valid_o = (occ != 2'd0);
  assign PC4_o   = Valid_o ? head.pc4  : '0;
  assign Inst_o  = Valid_o ? head.inst : NOP_INST;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        Clock_i = 1'b0;
  logic        Reset_n_i = 1'b0;
  logic        Stall_i = 1'b0;
  logic        Redirect_i = 1'b0;
  logic [31:0] RedirectPC_i = '0;
  logic        IMemReq_o;
  logic [31:0] IMemAddr_o;
  logic        IMemAck_i = 1'b0;
  logic [31:0] IMemData_i = '0;
  logic        Valid_o;
  logic [31:0] PC4_o;
  logic [31:0] Inst_o;

  logic        req_w, valid_w;
  logic [31:0] addr_w, pc4_w, inst_w, data_w;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  assign data_w = memword(addr_w);

  always #5 Clock_i = ~Clock_i;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clock_i(Clock_i), .Reset_n_i(Reset_n_i), .Stall_i(Stall_i),
    .Redirect_i(Redirect_i), .RedirectPC_i(RedirectPC_i),
    .IMemReq_o(IMemReq_o), .IMemAddr_o(IMemAddr_o),
    .IMemAck_i(IMemAck_i), .IMemData_i(IMemData_i),
    .Valid_o(Valid_o), .PC4_o(PC4_o), .Inst_o(Inst_o)
  );

  // Second instance starting just below the address wrap, on a zero-wait memory.
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clock_i(Clock_i), .Reset_n_i(Reset_n_i), .Stall_i(1'b0),
    .Redirect_i(1'b0), .RedirectPC_i(32'h0),
    .IMemReq_o(req_w), .IMemAddr_o(addr_w),
    .IMemAck_i(req_w), .IMemData_i(data_w),
    .Valid_o(valid_w), .PC4_o(pc4_w), .Inst_o(inst_w)
  );

  // Reference model: buffered entries as a queue, plus the outstanding request.
  typedef struct {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic        m_req;
  logic        m_discard;
  logic [31:0] m_addr;
  logic [31:0] m_npc;

  int unsigned wait_cnt;
  int unsigned lat_min = 0;
  int unsigned lat_max = 0;
  logic        spurious = 1'b0;

  function automatic logic [97:0] exp_view();
    logic v;
    v = (mq.size() != 0);
    return {v, v ? mq[0].pc4 : 32'h0, v ? mq[0].inst : 32'h0, m_req, m_addr};
  endfunction

  function automatic logic [97:0] dut_view();
    return {Valid_o, PC4_o, Inst_o, IMemReq_o, IMemAddr_o};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_req     = 1'b0;
    m_discard = 1'b0;
    m_addr    = '0;
    m_npc     = 32'h0;
  endfunction

  // Drive one cycle of inputs at a falling edge, advance the model, wait for the next falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    logic ack, done;
    ent_t e;
    Stall_i = s; Redirect_i = r; RedirectPC_i = rpc;
    if (m_req) begin
      ack = (wait_cnt == 0);
      if (wait_cnt != 0) wait_cnt--;
    end else begin
      ack = spurious && ($urandom_range(0, 3) == 0);
    end
    IMemAck_i  = ack;
    IMemData_i = (ack && m_req) ? memword(m_addr) : $urandom;
    done = m_req && ack;
    if (done) wait_cnt = $urandom_range(lat_max, lat_min);

    if (r) begin
      mq.delete();
    end else begin
      if (!s && mq.size() != 0) void'(mq.pop_front());
      if (done && !m_discard) begin
        e.pc4 = m_addr + 32'd4;
        e.inst = memword(m_addr);
        mq.push_back(e);
      end
    end

    if (r) begin
      m_npc = rpc & 32'hFFFF_FFFC;
      if (m_req && !done) m_discard = 1'b1;
      else begin m_req = 1'b0; m_discard = 1'b0; end
    end else if ((!m_req || done) && mq.size() <= 1) begin
      m_req = 1'b1; m_discard = 1'b0; m_addr = m_npc; m_npc = m_npc + 32'd4;
    end else if (done) begin
      m_req = 1'b0; m_discard = 1'b0;
    end
    @(negedge Clock_i);
  endtask

  task automatic apply_reset();
    Reset_n_i = 1'b0;
    Stall_i = 1'b0; Redirect_i = 1'b0; IMemAck_i = 1'b0;
    model_reset();
    wait_cnt = $urandom_range(lat_max, lat_min);
    repeat (2) @(negedge Clock_i);
    Reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clock_i);
    Reset_n_i = 1'b0;
    #1;
    checks++;
    if (dut_view() !== 98'h0) begin
      errors++; $display("FAIL reset_state: got %h exp %h", dut_view(), 98'h0);
    end
    checks++;
    if ({req_w, valid_w, pc4_w, inst_w, addr_w} !== 97'h0) begin
      errors++; $display("FAIL reset_state_wrap: got %h exp 0", {req_w, valid_w, pc4_w, inst_w, addr_w});
    end
  endtask

  task automatic test_stream();
    lat_min = 0; lat_max = 0; spurious = 1'b0;
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (dut_view() !== exp_view()) begin
        errors++; $display("FAIL stream_model cyc %0d: got %h exp %h", k, dut_view(), exp_view());
      end
      checks++;
      if (IMemReq_o !== 1'b1 || IMemAddr_o !== 32'(4 * (k - 1))) begin
        errors++; $display("FAIL stream_addr cyc %0d: got req %b addr %h exp req 1 addr %h", k, IMemReq_o, IMemAddr_o, 32'(4 * (k - 1)));
      end
      if (k >= 2) begin
        checks++;
        if (Valid_o !== 1'b1 || PC4_o !== 32'(4 * (k - 1))) begin
          errors++; $display("FAIL stream_pc4 cyc %0d: got v %b pc4 %h exp v 1 pc4 %h", k, Valid_o, PC4_o, 32'(4 * (k - 1)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen_pc4, frozen_inst;
    frozen_pc4 = PC4_o; frozen_inst = Inst_o;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0);
      checks++;
      if (dut_view() !== exp_view()) begin
        errors++; $display("FAIL stall_model cyc %0d: got %h exp %h", k, dut_view(), exp_view());
      end
      checks++;
      if (PC4_o !== frozen_pc4 || Inst_o !== frozen_inst) begin
        errors++; $display("FAIL stall_frozen cyc %0d: got %h/%h exp %h/%h", k, PC4_o, Inst_o, frozen_pc4, frozen_inst);
      end
    end
    checks++;
    if (IMemReq_o !== 1'b0) begin
      errors++; $display("FAIL stall_req_drop: got %b exp 0", IMemReq_o);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (dut_view() !== exp_view()) begin
        errors++; $display("FAIL stall_drain cyc %0d: got %h exp %h", k, dut_view(), exp_view());
      end
      if (k == 0) begin
        checks++;
        if (PC4_o !== frozen_pc4 + 32'd4) begin
          errors++; $display("FAIL stall_order: got %h exp %h", PC4_o, frozen_pc4 + 32'd4);
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int n;
    lat_min = 2; lat_max = 2; spurious = 1'b0;
    apply_reset();
    n = 0;
    while (!(m_req && m_addr == 32'h8) && n < 40) begin
      step(1'b0, 1'b0, 32'h0); n++;
    end
    checks++;
    if (n >= 40 || IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h8) begin
      errors++; $display("FAIL kill_reach_addr8: got req %b addr %h exp req 1 addr 8", IMemReq_o, IMemAddr_o);
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0100);
    checks++;
    if (Valid_o !== 1'b0 || IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h8) begin
      errors++; $display("FAIL kill_hold: got v %b req %b addr %h exp v 0 req 1 addr 8", Valid_o, IMemReq_o, IMemAddr_o);
    end
    n = 0;
    while (!(IMemReq_o === 1'b1 && IMemAddr_o === 32'h100) && n < 20) begin
      step(1'b0, 1'b0, 32'h0); n++;
      checks++;
      if (dut_view() !== exp_view()) begin
        errors++; $display("FAIL kill_model cyc %0d: got %h exp %h", n, dut_view(), exp_view());
      end
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL kill_target_req: got addr %h exp 100 within 20 cycles", IMemAddr_o);
    end
    n = 0;
    while (Valid_o !== 1'b1 && n < 20) begin step(1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (Valid_o !== 1'b1 || PC4_o !== 32'h104) begin
      errors++; $display("FAIL kill_first_pc4: got v %b pc4 %h exp v 1 pc4 104", Valid_o, PC4_o);
    end
  endtask

  task automatic test_redirect_ack();
    lat_min = 0; lat_max = 0; spurious = 1'b0;
    apply_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0203);
    checks++;
    if (Valid_o !== 1'b0 || IMemReq_o !== 1'b0 || dut_view() !== exp_view()) begin
      errors++; $display("FAIL redir_ack_drop: got v %b req %b exp v 0 req 0", Valid_o, IMemReq_o);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h200 || Valid_o !== 1'b0) begin
      errors++; $display("FAIL redir_ack_target: got req %b addr %h v %b exp req 1 addr 200 v 0", IMemReq_o, IMemAddr_o, Valid_o);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (Valid_o !== 1'b1 || PC4_o !== 32'h204 || Inst_o !== memword(32'h200)) begin
      errors++; $display("FAIL redir_ack_first: got v %b pc4 %h inst %h exp v 1 pc4 204 inst %h", Valid_o, PC4_o, Inst_o, memword(32'h200));
    end
  endtask

  task automatic test_random();
    logic s, r;
    logic [31:0] t;
    lat_min = 0; lat_max = 3; spurious = 1'b1;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 2))
        0: t = $urandom;
        1: t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 255));
      endcase
      step(s, r, t);
      checks++;
      if (dut_view() !== exp_view()) begin
        errors++; $display("FAIL random_model cyc %0d: got %h exp %h", k, dut_view(), exp_view());
      end
    end
  endtask

  task automatic test_wrap();
    lat_min = 0; lat_max = 0; spurious = 1'b0;
    apply_reset();
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC || valid_w !== 1'b0) begin
      errors++; $display("FAIL wrap_first: got req %b addr %h v %b exp req 1 addr fffffffc v 0", req_w, addr_w, valid_w);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (addr_w !== 32'h0 || valid_w !== 1'b1 || pc4_w !== 32'h0 || inst_w !== memword(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_second: got addr %h v %b pc4 %h inst %h exp addr 0 v 1 pc4 0", addr_w, valid_w, pc4_w, inst_w);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (addr_w !== 32'h4 || pc4_w !== 32'h4) begin
      errors++; $display("FAIL wrap_third: got addr %h pc4 %h exp 4 4", addr_w, pc4_w);
    end
  endtask

  task automatic test_async_reset();
    lat_min = 0; lat_max = 0; spurious = 1'b0;
    apply_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0);
    checks++;
    if (IMemReq_o !== 1'b1 || Valid_o !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got req %b v %b exp 1 1", IMemReq_o, Valid_o);
    end
    #2;
    Reset_n_i = 1'b0;
    IMemAck_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({IMemReq_o, Valid_o, PC4_o, Inst_o} !== 66'h0) begin
      errors++; $display("FAIL areset_immediate: got %h exp 0", {IMemReq_o, Valid_o, PC4_o, Inst_o});
    end
    @(negedge Clock_i);
    checks++;
    if (dut_view() !== 98'h0) begin
      errors++; $display("FAIL areset_hold_ack: got %h exp 0", dut_view());
    end
    Reset_n_i = 1'b1;
    IMemAck_i = 1'b0;
    wait_cnt = 0;
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (IMemReq_o !== 1'b1 || IMemAddr_o !== 32'h0 || dut_view() !== exp_view()) begin
      errors++; $display("FAIL areset_restart: got req %b addr %h exp req 1 addr 0", IMemReq_o, IMemAddr_o);
    end
  endtask

  initial begin
    model_reset();
    wait_cnt = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
